mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_AW, default 10, meaning log2 of memory depth in 64-bit dwords.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each response (range 0-15).
REQ-003 The block SHALL have port HCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port HRESET, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port PTRANS, input, 1 bit: request valid from the arbitrated memory port.
REQ-006 The block SHALL have port PADDR, input, 64 bits: byte address of the request.
REQ-007 The block SHALL have port HWRITE, input, 1 bit: 1 = write, 0 = read.
REQ-008 The block SHALL have port PDATA, input, 64 bits: write data, lane-aligned to PADDR[2:0].
REQ-009 The block SHALL have port HSIZE, input, 2 bits: access size 0 = byte, 1 = half, 2 = word, 3 = dword.
REQ-010 The block SHALL have port HRDATA, output, 64 bits: aligned read dword.
REQ-011 The block SHALL have port HREADY, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port HRESP, output, 1 bit: error flag, valid only while HREADY=1.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT, RESP and ERR.
REQ-014 Request sampling SHALL occur only in IDLE; PTRANS in any other state SHALL be ignored, and the requester SHALL hold the request until HREADY.
REQ-015 In IDLE with PTRANS=1, the block SHALL register PADDR, HWRITE, PDATA and HSIZE.
REQ-016 From IDLE, the next state SHALL be ERR if the request is misaligned (PADDR mod 2^HSIZE != 0) or out of range (PADDR[63:MEM_AW+3] != 0).
REQ-017 Otherwise the next state SHALL be RESP when WAIT_CYCLES=0, else WAIT with the wait counter loaded to WAIT_CYCLES-1.
REQ-018 In WAIT, the counter SHALL decrement each cycle and the FSM SHALL move to RESP in the cycle after the counter reaches 0.
REQ-019 A valid request accepted in cycle N SHALL produce HREADY=1, HRESP=0 in cycle N+1+WAIT_CYCLES, for exactly one cycle.
REQ-020 RESP SHALL always return to IDLE, so the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-021 ERR SHALL assert HREADY=1 and HRESP=1 in cycle N+1 for one cycle, perform no memory write, leave HRDATA unchanged, and return to IDLE.
REQ-022 A write SHALL update memory on the rising edge ending the RESP cycle.
REQ-023 Write byte enables SHALL cover (1<<HSIZE) bytes starting at lane PADDR[2:0]; other bytes SHALL be unchanged.
REQ-024 For a read, HRDATA SHALL present mem[PADDR[MEM_AW+2:3]] during RESP and hold that value until the next read completes.
REQ-025 A write SHALL NOT change HRDATA.
REQ-026 HREADY and HRESP SHALL be 0 in IDLE and WAIT.
REQ-027 Memory contents SHALL NOT be reset; reads of unwritten locations return X in simulation.

Reset
REQ-028 Asserting HRESET=0 SHALL immediately force state IDLE, wait counter 0, HREADY=0, HRESP=0 and HRDATA=0.
REQ-029 Reset asserted mid-request (WAIT or RESP) SHALL abort the request with no memory write.
REQ-030 The first request SHALL be sampled on the first rising HCLK edge after HRESET returns to 1.

Structure
REQ-031 The state encoding, the HSIZE encodings and the default WAIT_CYCLES SHALL reside in the shared package mem_pkg, for reuse by mem_controller.
REQ-032 The storage array SHALL be a sub-module mem_bank_sp: a single-port, byte-enabled, 2^MEM_AW x 64 array with synchronous write and combinational read.

Verification
REQ-033 Default parameters: a dword write to 0x40 of 0x1122334455667788, then a read of 0x40, SHALL give HREADY 3 cycles after each accept and HRDATA=0x1122334455667788.
REQ-034 A byte write of PDATA=0xAB00 to 0x41 after the dword of REQ-033 SHALL make a read of 0x40 return 0x112233445566AB88.
REQ-035 A half read of 0x43 SHALL produce ERR: HREADY=1 and HRESP=1 in the cycle after accept, with HRDATA unchanged.
REQ-036 A read of address 1<<13 (out of range at MEM_AW=10) SHALL produce an ERR response, with memory unchanged.
REQ-037 With WAIT_CYCLES=0, continuously held PTRANS=1 requests SHALL complete every 2 cycles, with an HREADY pulse each time.
REQ-038 HRESET pulsed low during WAIT of a write to 0x80 SHALL leave mem[0x80] unchanged, with HREADY never asserted for that write.

Source files
------------

// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg -- shared definitions for the memory responder and mem_controller.
//
// Contents:
//   state_t             : responder FSM state encoding (IDLE, WAIT, RESP, ERR)
//   hsize_t             : access size encoding carried on HSIZE
//   WAIT_CYCLES_DEFAULT : default number of wait states before a response
//   CNT_W               : width of the wait-state counter (holds 0..15)
//   LANES               : byte lanes in one 64-bit dword
//   misaligned()        : true when a byte lane is not a multiple of the size
//   byte_enables()      : lane mask covering (1 << size) bytes from a lane
// -----------------------------------------------------------------------------
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } hsize_t;

  localparam int WAIT_CYCLES_DEFAULT = 2;
  localparam int CNT_W               = 4;
  localparam int LANES               = 8;

  // Only the low three address bits matter for alignment inside a dword.
  function automatic logic misaligned(input logic [2:0] lane, input hsize_t sz);
    logic bad;
    case (sz)
      SZ_BYTE:  bad = 1'b0;
      SZ_HALF:  bad = lane[0];
      SZ_WORD:  bad = |lane[1:0];
      default:  bad = |lane;
    endcase
    return bad;
  endfunction

  // Aligned accesses never run past lane 7, so an 8-bit shift cannot lose
  // any enabled byte.
  function automatic logic [LANES-1:0] byte_enables(input logic [2:0] lane,
                                                    input hsize_t   sz);
    logic [LANES-1:0] mask;
    case (sz)
      SZ_BYTE:  mask = 8'h01;
      SZ_HALF:  mask = 8'h03;
      SZ_WORD:  mask = 8'h0F;
      default:  mask = 8'hFF;
    endcase
    return mask << lane;
  endfunction

endpackage

// File: rtl/mem_bank_sp.sv
// -----------------------------------------------------------------------------
// mem_bank_sp -- single-port, byte-enabled storage array, 2^AW x DATA_W.
//
// Write is synchronous (rising clk, gated by we and per-byte be); read is
// combinational from the same address. Contents are never reset.
//
// Ports:
//   clk   : clock
//   we    : write enable
//   be    : byte enables, one per 8-bit lane of wdata
//   addr  : word address
//   wdata : write data, lane aligned
//   rdata : combinational read data at addr
// -----------------------------------------------------------------------------
module mem_bank_sp #(
  parameter int AW     = 10,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder -- memory-port slave with programmable wait states.
//
// A request is sampled only while idle. Misaligned or out-of-range requests
// answer one cycle later with an error pulse; valid ones answer after
// WAIT_CYCLES wait states with a one-cycle HREADY pulse. Writes commit on the
// edge that ends the response cycle. Read data is shown live during the
// response cycle and held afterwards until the next read completes.
//
// Ports:
//   HCLK   : clock
//   HRESET : asynchronous active-low reset
//   PTRANS : request valid, held by the requester until HREADY
//   PADDR  : byte address
//   HWRITE : 1 = write, 0 = read
//   PDATA  : write data, lane aligned to PADDR[2:0]
//   HSIZE  : 0 byte, 1 half, 2 word, 3 dword
//   HRDATA : read dword
//   HREADY : one-cycle completion pulse
//   HRESP  : error flag, meaningful only with HREADY
// -----------------------------------------------------------------------------
module mem_responder
  import mem_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        PTRANS,
  input  logic [63:0] PADDR,
  input  logic        HWRITE,
  input  logic [63:0] PDATA,
  input  logic [1:0]  HSIZE,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  // First WAIT cycle already counts as one wait state.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MEM_AW+2:0]  addr_q;
  logic               write_q;
  logic [63:0]        wdata_q;
  hsize_t             size_q;
  logic [63:0]        hrdata_q;

  logic               accept;
  logic               req_err;
  logic               mem_we;
  logic [LANES-1:0]   mem_be;
  logic [63:0]        mem_rdata;

  assign accept  = (state_q == ST_IDLE) && PTRANS;
  assign req_err = misaligned(PADDR[2:0], hsize_t'(HSIZE)) ||
                   (|(PADDR >> (MEM_AW + 3)));

  // ---- state register ----
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (PTRANS) begin
          if (req_err) begin
            state_d = ST_ERR;
          end else if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- request capture ----
  always_ff @(posedge HCLK) begin
    if (accept) begin
      addr_q  <= PADDR[MEM_AW+2:0];
      write_q <= HWRITE;
      wdata_q <= PDATA;
      size_q  <= hsize_t'(HSIZE);
    end
  end

  // ---- storage ----
  // Writes only in RESP, so ERR and an aborted WAIT never touch the array.
  assign mem_we = (state_q == ST_RESP) && write_q;
  assign mem_be = byte_enables(addr_q[2:0], size_q);

  mem_bank_sp #(
    .AW     (MEM_AW),
    .DATA_W (64)
  ) u_bank (
    .clk   (HCLK),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (addr_q[MEM_AW+2:3]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // ---- read data hold ----
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      hrdata_q <= '0;
    end else if ((state_q == ST_RESP) && !write_q) begin
      hrdata_q <= mem_rdata;
    end
  end

  // ---- outputs ----
  assign HRDATA = ((state_q == ST_RESP) && !write_q) ? mem_rdata : hrdata_q;
  assign HREADY = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign HRESP  = (state_q == ST_ERR);

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int MEM_AW = 10;
  localparam int WC     = 2;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b0;
  logic        PTRANS = 1'b0;
  logic [63:0] PADDR = '0;
  logic        HWRITE = 1'b0;
  logic [63:0] PDATA = '0;
  logic [1:0]  HSIZE = '0;
  logic [63:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  // second instance with zero wait states, own request port
  logic        ptrans_z = 1'b0;
  logic [63:0] paddr_z = '0;
  logic        hwrite_z = 1'b0;
  logic [63:0] pdata_z = '0;
  logic [1:0]  hsize_z = '0;
  logic [63:0] hrdata_z;
  logic        hready_z;
  logic        hresp_z;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  mem_responder #(.MEM_AW(MEM_AW), .WAIT_CYCLES(WC)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .PTRANS(PTRANS), .PADDR(PADDR),
    .HWRITE(HWRITE), .PDATA(PDATA), .HSIZE(HSIZE),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP));

  mem_responder #(.MEM_AW(MEM_AW), .WAIT_CYCLES(0)) dut_z (
    .HCLK(HCLK), .HRESET(HRESET), .PTRANS(ptrans_z), .PADDR(paddr_z),
    .HWRITE(hwrite_z), .PDATA(pdata_z), .HSIZE(hsize_z),
    .HRDATA(hrdata_z), .HREADY(hready_z), .HRESP(hresp_z));

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model of the main instance ----------------
  logic [63:0] mmem [2**MEM_AW];
  bit          pend_vld = 0;
  int          pend_cyc;
  bit          pend_err, pend_wr;
  logic [63:0] pend_addr, pend_data;
  int          pend_nbytes;
  logic [63:0] exp_rdata = '0;
  bit          was_idle;

  function automatic bit is_err(input logic [63:0] a, input int nbytes);
    return ((a % nbytes) != 0) || ((a >> (MEM_AW + 3)) != 0);
  endfunction

  always @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      pend_vld  = 0;
      exp_rdata = '0;
    end else begin
      was_idle = !pend_vld;
      if (pend_vld && cyc == pend_cyc) begin
        if (!pend_err) begin
          if (pend_wr) begin
            for (int b = 0; b < 8; b++)
              if (b >= int'(pend_addr[2:0]) && b < int'(pend_addr[2:0]) + pend_nbytes)
                mmem[pend_addr[MEM_AW+2:3]][8*b +: 8] = pend_data[8*b +: 8];
          end else begin
            exp_rdata = mmem[pend_addr[MEM_AW+2:3]];
          end
        end
        pend_vld = 0;
      end
      if (was_idle && PTRANS) begin
        pend_vld    = 1;
        pend_nbytes = 1 << HSIZE;
        pend_err    = is_err(PADDR, pend_nbytes);
        pend_cyc    = cyc + 1 + (pend_err ? 0 : WC);
        pend_wr     = HWRITE;
        pend_addr   = PADDR;
        pend_data   = PDATA;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge HCLK) begin
    bit          resp_now;
    logic [63:0] exp_d;
    if (!HRESET) begin
      chk("rst_hready", {63'd0, HREADY}, 64'd0);
      chk("rst_hresp",  {63'd0, HRESP},  64'd0);
      chk("rst_hrdata", HRDATA, 64'd0);
    end else begin
      resp_now = pend_vld && (cyc == pend_cyc);
      exp_d = (resp_now && !pend_err && !pend_wr) ? mmem[pend_addr[MEM_AW+2:3]] : exp_rdata;
      chk("hready", {63'd0, HREADY}, {63'd0, resp_now});
      chk("hresp",  {63'd0, HRESP},  {63'd0, resp_now && pend_err});
      chk("hrdata", HRDATA, exp_d);
    end
  end

  // ---------------- directed driver ----------------
  task automatic req(input logic [63:0] a, input logic wr, input logic [63:0] d,
                     input logic [1:0] sz, input int exp_lat, input logic exp_err);
    int c0;
    bit seen;
    @(posedge HCLK); #1;
    PTRANS = 1'b1; PADDR = a; HWRITE = wr; PDATA = d; HSIZE = sz;
    c0 = cyc;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge HCLK);
      if (HREADY) seen = 1;
    end
    if (!seen) begin
      chk("req_timeout", 64'd0, 64'd1);
    end else begin
      chk("latency", 64'(cyc - c0), 64'(exp_lat));
      chk("resp_flag", {63'd0, HRESP}, {63'd0, exp_err});
    end
    @(posedge HCLK); #1;
    PTRANS = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge HCLK);
    chk("reset_hrdata_lit", HRDATA, 64'd0);
    chk("reset_hready_z", {63'd0, hready_z}, 64'd0);
    #1 HRESET = 1'b1;

    // dword write then read
    req(64'h40, 1'b1, 64'h1122334455667788, 2'd3, 3, 1'b0);
    req(64'h40, 1'b0, 64'h0, 2'd3, 3, 1'b0);
    chk("dword_read_lit", HRDATA, 64'h1122334455667788);

    // byte write into lane 1; HRDATA must not move on a write
    req(64'h41, 1'b1, 64'h0000_0000_0000_AB00, 2'd0, 3, 1'b0);
    chk("write_keeps_hrdata", HRDATA, 64'h1122334455667788);
    req(64'h40, 1'b0, 64'h0, 2'd3, 3, 1'b0);
    chk("byte_merge_lit", HRDATA, 64'h112233445566AB88);
    chk("model_pin", mmem[8], 64'h112233445566AB88);

    // misaligned half read
    req(64'h43, 1'b0, 64'h0, 2'd1, 1, 1'b1);
    chk("err_keeps_hrdata", HRDATA, 64'h112233445566AB88);

    // out of range read, and out of range write that would alias 0x40
    req(64'h2000, 1'b0, 64'h0, 2'd3, 1, 1'b1);
    req(64'h2040, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1, 1'b1);
    // misaligned word write
    req(64'h42, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 1, 1'b1);
    req(64'h40, 1'b0, 64'h0, 2'd3, 3, 1'b0);
    chk("err_no_write_lit", HRDATA, 64'h112233445566AB88);

    // known contents at 0x80, then abort a write there with reset in WAIT
    req(64'h80, 1'b1, 64'h0123456789ABCDEF, 2'd3, 3, 1'b0);
    @(posedge HCLK); #1;
    PTRANS = 1'b1; PADDR = 64'h80; HWRITE = 1'b1; PDATA = 64'hDEAD_BEEF_DEAD_BEEF; HSIZE = 2'd3;
    @(posedge HCLK); #1;
    PTRANS = 1'b0;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("abort_hrdata_lit", HRDATA, 64'd0);
    #1 HRESET = 1'b1;
    repeat (5) @(negedge HCLK);
    req(64'h80, 1'b0, 64'h0, 2'd3, 3, 1'b0);
    chk("abort_no_write_lit", HRDATA, 64'h0123456789ABCDEF);

    // upper-word write, upper bytes merge
    req(64'h84, 1'b1, 64'hA5A5A5A5_00000000, 2'd2, 3, 1'b0);
    req(64'h80, 1'b0, 64'h0, 2'd3, 3, 1'b0);
    chk("word_merge_lit", HRDATA, 64'hA5A5A5A589ABCDEF);

    // zero-wait instance: write, then hold a read request continuously
    @(posedge HCLK); #1;
    ptrans_z = 1'b1; paddr_z = 64'h10; hwrite_z = 1'b1; pdata_z = 64'hCAFEF00D12345678; hsize_z = 2'd3;
    @(negedge HCLK);
    chk("z_wr_idle", {63'd0, hready_z}, 64'd0);
    @(negedge HCLK);
    chk("z_wr_ready", {63'd0, hready_z}, 64'd1);
    @(posedge HCLK); #1;
    hwrite_z = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge HCLK);
      chk("z_held_ready", {63'd0, hready_z}, 64'(k % 2));
      chk("z_held_resp", {63'd0, hresp_z}, 64'd0);
      if (k % 2 == 1) chk("z_held_data", hrdata_z, 64'hCAFEF00D12345678);
    end
    @(posedge HCLK); #1;
    ptrans_z = 1'b0;
    repeat (3) @(negedge HCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
